// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// mux-select codes, ALUOp and ALU_CONTROL values. TRAP state exists only with CTRL_TRAP_EN.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH,
`ifdef CTRL_TRAP_EN
      S_JAL,
      S_TRAP
`else
      S_JAL
`endif
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALURES  = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b011;
   localparam logic [2:0] ALUC_SLT = 3'b101;

   // Immediate format depends only on the opcode, so the extender can run in every state.
   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:  imm_src_of = IMM_S;
         OP_BRANCH: imm_src_of = IMM_B;
         OP_JAL:    imm_src_of = IMM_J;
         default:   imm_src_of = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to ALU_CONTROL.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALUC_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALUC_ADD;
         ALUOP_SUB: alu_control = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7[5] only means sub for register-register ops; addi reuses that bit as immediate
               3'b000:  alu_control = (funct7b5 & op5) ? ALUC_SUB : ALUC_ADD;
               3'b010:  alu_control = ALUC_SLT;
               3'b110:  alu_control = ALUC_OR;
               3'b111:  alu_control = ALUC_AND;
               default: alu_control = ALUC_ADD;
            endcase
         end
         default: alu_control = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core with unified memory handshake.
// Optional CTRL_TRAP_EN: unknown opcodes park the FSM in TRAP and raise sticky ILLEGAL.
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic [6:0] OP,
   input  logic [2:0] FUNCT3,
   input  logic       FUNCT7B5,
   input  logic       ZERO,
   input  logic       MEM_READY,
   output logic       MEM_REQ,
   output logic       MEM_WRITE,
   output logic       ADR_SRC,
   output logic       IR_WRITE,
   output logic       PC_WRITE,
   output logic       REG_WRITE,
   output logic [1:0] RESULT_SRC,
   output logic [1:0] ALU_SRC_A,
   output logic [1:0] ALU_SRC_B,
   output logic [1:0] IMM_SRC,
   output logic [2:0] ALU_CONTROL,
   output logic       ILLEGAL
);

   state_t     state, state_next;
   logic [1:0] alu_op;

   always_ff @(posedge CLK) begin
      if (RESET) state <= S_FETCH;
      else       state <= state_next;
   end

`ifdef CTRL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge CLK) begin
      if (RESET)                   illegal_q <= 1'b0;
      else if (state_next == S_TRAP) illegal_q <= 1'b1;
   end
   assign ILLEGAL = illegal_q;
`else
   assign ILLEGAL = 1'b0;
`endif

   assign IMM_SRC = imm_src_of(OP);

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (FUNCT3),
      .funct7b5    (FUNCT7B5),
      .op5         (OP[5]),
      .alu_control (ALU_CONTROL)
   );

   always_comb begin
      state_next = state;
      MEM_REQ    = 1'b0;
      MEM_WRITE  = 1'b0;
      ADR_SRC    = 1'b0;
      IR_WRITE   = 1'b0;
      PC_WRITE   = 1'b0;
      REG_WRITE  = 1'b0;
      RESULT_SRC = RES_ALUOUT;
      ALU_SRC_A  = SRCA_PC;
      ALU_SRC_B  = SRCB_RS2;
      alu_op     = ALUOP_ADD;

      case (state)
         S_FETCH: begin
            MEM_REQ    = 1'b1;
            ALU_SRC_A  = SRCA_PC;
            ALU_SRC_B  = SRCB_FOUR;
            RESULT_SRC = RES_ALURES;
            if (MEM_READY) begin
               IR_WRITE   = 1'b1;
               PC_WRITE   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // Precompute branch/jump target into ALUOut while the opcode is decoded.
            ALU_SRC_A = SRCA_OLDPC;
            ALU_SRC_B = SRCB_IMM;
            case (OP)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECUTER;
               OP_ITYPE:          state_next = S_EXECUTEI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
`ifdef CTRL_TRAP_EN
               default:           state_next = S_TRAP;
`else
               default:           state_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            ALU_SRC_A  = SRCA_RS1;
            ALU_SRC_B  = SRCB_IMM;
            state_next = OP[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            MEM_REQ = 1'b1;
            ADR_SRC = 1'b1;
            if (MEM_READY) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            RESULT_SRC = RES_MEMDATA;
            REG_WRITE  = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWRITE: begin
            MEM_REQ   = 1'b1;
            MEM_WRITE = 1'b1;
            ADR_SRC   = 1'b1;
            if (MEM_READY) state_next = S_FETCH;
         end
         S_EXECUTER: begin
            ALU_SRC_A  = SRCA_RS1;
            ALU_SRC_B  = SRCB_RS2;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALU_SRC_A  = SRCA_RS1;
            ALU_SRC_B  = SRCB_IMM;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            RESULT_SRC = RES_ALUOUT;
            REG_WRITE  = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            ALU_SRC_A  = SRCA_RS1;
            ALU_SRC_B  = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            RESULT_SRC = RES_ALUOUT;
            // funct3[0] distinguishes bne from beq
            PC_WRITE   = ZERO ^ FUNCT3[0];
            state_next = S_FETCH;
         end
         S_JAL: begin
            ALU_SRC_A  = SRCA_OLDPC;
            ALU_SRC_B  = SRCB_FOUR;
            RESULT_SRC = RES_ALUOUT;
            PC_WRITE   = 1'b1;
            state_next = S_ALUWB;
         end
`ifdef CTRL_TRAP_EN
         S_TRAP: state_next = S_TRAP;
`endif
         default: state_next = S_FETCH;
      endcase

      // Reset abandons any in-flight access without letting a strobe escape this cycle.
      if (RESET) begin
         MEM_REQ   = 1'b0;
         MEM_WRITE = 1'b0;
         IR_WRITE  = 1'b0;
         PC_WRITE  = 1'b0;
         REG_WRITE = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output vectors are queued
// as stimulus is driven, a negedge monitor queues observed vectors, each task compares them.
module tb_multicycle_controller;

   typedef struct packed {
      logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
      logic [1:0] result_src, src_a, src_b, imm_src;
      logic [2:0] alu_control;
      logic       illegal;
   } outs_t;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [6:0] OP = 7'b0110011;
   logic [2:0] FUNCT3 = 3'b000;
   logic       FUNCT7B5 = 1'b0;
   logic       ZERO = 1'b0;
   logic       MEM_READY = 1'b0;
   logic       MEM_REQ, MEM_WRITE, ADR_SRC, IR_WRITE, PC_WRITE, REG_WRITE, ILLEGAL;
   logic [1:0] RESULT_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC;
   logic [2:0] ALU_CONTROL;

   multicycle_controller dut (
      .CLK(CLK), .RESET(RESET), .OP(OP), .FUNCT3(FUNCT3), .FUNCT7B5(FUNCT7B5), .ZERO(ZERO),
      .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ), .MEM_WRITE(MEM_WRITE), .ADR_SRC(ADR_SRC),
      .IR_WRITE(IR_WRITE), .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE), .RESULT_SRC(RESULT_SRC),
      .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .IMM_SRC(IMM_SRC), .ALU_CONTROL(ALU_CONTROL),
      .ILLEGAL(ILLEGAL)
   );

   always #5 CLK = ~CLK;

   outs_t exp_q[$];
   outs_t obs_q[$];
   logic  mon_en = 1'b0;
   int    checks = 0;
   int    passed = 0;

   always @(negedge CLK)
      if (mon_en)
         obs_q.push_back({MEM_REQ, MEM_WRITE, ADR_SRC, IR_WRITE, PC_WRITE, REG_WRITE,
                          RESULT_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC, ALU_CONTROL, ILLEGAL});

   function automatic outs_t mk(input logic req, wr, adr, irw, pcw, rw,
                                input logic [1:0] rs, sa, sb, imm,
                                input logic [2:0] alu, input logic ill);
      mk = {req, wr, adr, irw, pcw, rw, rs, sa, sb, imm, alu, ill};
   endfunction

   // Expected vectors for the recurring states, straight from the state table.
   function automatic outs_t e_fetch(input logic rdy, input logic [1:0] imm);
      e_fetch = mk(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
   endfunction
   function automatic outs_t e_decode(input logic [1:0] imm);
      e_decode = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
   endfunction
   function automatic outs_t e_aluwb(input logic [1:0] imm);
      e_aluwb = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
   endfunction

   // Drive one cycle of inputs, queue its expected outputs, advance to just past the next edge.
   task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7, z, rdy, rst,
                       input outs_t e);
      OP = op; FUNCT3 = f3; FUNCT7B5 = f7; ZERO = z; MEM_READY = rdy; RESET = rst;
      mon_en = 1'b1;
      exp_q.push_back(e);
      @(posedge CLK); #1;
   endtask

   task automatic apply_reset();
      mon_en = 1'b0;
      RESET = 1'b1; MEM_READY = 1'b0;
      @(posedge CLK); #1;
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      outs_t e, o;
      apply_reset();
      // Reset held with MEM_READY high: strobes suppressed, FETCH selects visible
      step(7'b0110011, 3'b000, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
      step(7'b0110011, 3'b000, 0, 0, 0, 0, e_fetch(0, 2'b00));
      step(7'b0110011, 3'b000, 0, 0, 1, 0, e_fetch(1, 2'b00));
      step(7'b0110011, 3'b000, 0, 0, 0, 1, e_decode(2'b00));
      step(7'b0110011, 3'b000, 0, 0, 0, 0, e_fetch(0, 2'b00));
      mon_en = 1'b0;
      checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL reset count: got %0d want %0d", obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) $display("FAIL reset cyc%0d: got %h want %h", i, o, e);
         else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_alu_ops();
      outs_t e, o;
      logic [6:0] ops [7] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011};
      logic [2:0] f3s [7] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b100};
      logic       f7s [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [2:0] alus[7] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b011, 3'b101, 3'b000};
      logic [1:0] sb;
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         sb = ops[k][5] ? 2'b00 : 2'b01;
         step(ops[k], f3s[k], f7s[k], 0, 1, 0, e_fetch(1, 2'b00));
         step(ops[k], f3s[k], f7s[k], 0, 0, 0, e_decode(2'b00));
         step(ops[k], f3s[k], f7s[k], 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, sb, 2'b00, alus[k], 0));
         step(ops[k], f3s[k], f7s[k], 0, 1, 0, e_aluwb(2'b00));
      end
      mon_en = 1'b0;
      checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL alu count: got %0d want %0d", obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) $display("FAIL alu cyc%0d: got %h want %h", i, o, e);
         else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_load_store();
      outs_t e, o;
      outs_t memadr_e;
      apply_reset();
      memadr_e = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
      // lw with a fetch stall and three stalled MEMREAD cycles
      step(7'b0000011, 3'b010, 0, 0, 0, 0, e_fetch(0, 2'b00));
      step(7'b0000011, 3'b010, 0, 0, 1, 0, e_fetch(1, 2'b00));
      step(7'b0000011, 3'b010, 0, 0, 1, 0, e_decode(2'b00));
      step(7'b0000011, 3'b010, 0, 0, 1, 0, memadr_e);
      for (int k = 0; k < 3; k++)
         step(7'b0000011, 3'b010, 0, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      step(7'b0000011, 3'b010, 0, 0, 1, 0, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      step(7'b0000011, 3'b010, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      // sw, with one stalled MEMWRITE cycle
      memadr_e.imm_src = 2'b01;
      step(7'b0100011, 3'b010, 0, 0, 1, 0, e_fetch(1, 2'b01));
      step(7'b0100011, 3'b010, 0, 0, 1, 0, e_decode(2'b01));
      step(7'b0100011, 3'b010, 0, 0, 1, 0, memadr_e);
      step(7'b0100011, 3'b010, 0, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
      step(7'b0100011, 3'b010, 0, 0, 1, 0, mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
      step(7'b0100011, 3'b010, 0, 0, 0, 0, e_fetch(0, 2'b01));
      mon_en = 1'b0;
      checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL ldst count: got %0d want %0d", obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) $display("FAIL ldst cyc%0d: got %h want %h", i, o, e);
         else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_branch_jal();
      outs_t e, o;
      logic [2:0] f3s[3] = '{3'b000, 3'b001, 3'b000};
      logic       zs [3] = '{1'b1, 1'b1, 1'b0};
      logic       tk [3] = '{1'b1, 1'b0, 1'b0};
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         step(7'b1100011, f3s[k], 0, zs[k], 1, 0, e_fetch(1, 2'b10));
         step(7'b1100011, f3s[k], 0, zs[k], 1, 0, e_decode(2'b10));
         step(7'b1100011, f3s[k], 0, zs[k], 1, 0, mk(0, 0, 0, 0, tk[k], 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
      end
      step(7'b1101111, 3'b000, 0, 0, 1, 0, e_fetch(1, 2'b11));
      step(7'b1101111, 3'b000, 0, 0, 1, 0, e_decode(2'b11));
      step(7'b1101111, 3'b000, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
      step(7'b1101111, 3'b000, 0, 0, 1, 0, e_aluwb(2'b11));
      step(7'b1101111, 3'b000, 0, 0, 0, 0, e_fetch(0, 2'b11));
      mon_en = 1'b0;
      checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL brj count: got %0d want %0d", obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) $display("FAIL brj cyc%0d: got %h want %h", i, o, e);
         else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_illegal();
      outs_t e, o;
      apply_reset();
      step(7'b1111111, 3'b000, 0, 0, 1, 0, e_fetch(1, 2'b00));
      step(7'b1111111, 3'b000, 0, 0, 1, 0, e_decode(2'b00));
`ifdef CTRL_TRAP_EN
      for (int k = 0; k < 4; k++)
         step(7'b1111111, 3'b000, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
`else
      step(7'b1111111, 3'b000, 0, 0, 1, 0, e_fetch(1, 2'b00));
      step(7'b1111111, 3'b000, 0, 0, 1, 0, e_decode(2'b00));
`endif
      mon_en = 1'b0;
      checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL illegal count: got %0d want %0d", obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) $display("FAIL illegal cyc%0d: got %h want %h", i, o, e);
         else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_write();
      outs_t e, o;
      apply_reset();
      step(7'b0100011, 3'b010, 0, 0, 1, 0, e_fetch(1, 2'b01));
      step(7'b0100011, 3'b010, 0, 0, 1, 0, e_decode(2'b01));
      step(7'b0100011, 3'b010, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
      // In MEMWRITE with MEM_READY high, reset must suppress the store strobe
      step(7'b0100011, 3'b010, 0, 0, 1, 1, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
      step(7'b0100011, 3'b010, 0, 0, 0, 0, e_fetch(0, 2'b01));
      mon_en = 1'b0;
      checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL rstwr count: got %0d want %0d", obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) $display("FAIL rstwr cyc%0d: got %h want %h", i, o, e);
         else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_load_store();
      test_branch_jal();
      test_illegal();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
